alu_pipe_core: RTL and testbench

- Parametrised ALU core and successor to the fixed 8-bit ALU: operand width W and operand-pairing timeout are parameters.
- Adds a registered result-valid strobe, a busy indication, two-cycle multiply ops and width-generic rotate error checking.
- Sits behind the ALU driver/monitor interface as the DUT; all outputs are registered.

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_exec.sv | 133 +++++++++++++
 rtl/alu_pipe_core.sv | 190 +++++++++++++++++++
 tb/tb_alu_pipe_core.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, state and operand-requirement definitions for the pipelined ALU core.
package alu_pkg;

  typedef enum logic [3:0] {
    ArithAdd    = 4'd0,
    ArithSub    = 4'd1,
    ArithAddCin = 4'd2,
    ArithSubCin = 4'd3,
    ArithIncA   = 4'd4,
    ArithDecA   = 4'd5,
    ArithIncB   = 4'd6,
    ArithDecB   = 4'd7,
    ArithCmp    = 4'd8,
    ArithMulInc = 4'd9,
    ArithMulShl = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    LogicAnd   = 4'd0,
    LogicNand  = 4'd1,
    LogicOr    = 4'd2,
    LogicNor   = 4'd3,
    LogicXor   = 4'd4,
    LogicXnor  = 4'd5,
    LogicNotA  = 4'd6,
    LogicNotB  = 4'd7,
    LogicShr1A = 4'd8,
    LogicShl1A = 4'd9,
    LogicShr1B = 4'd10,
    LogicShl1B = 4'd11,
    LogicRolAB = 4'd12,
    LogicRorAB = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {StIdle, StWaitA, StWaitB, StMul} state_e;

  // Bit n set: opcode n consumes only that operand.
  localparam logic [15:0] ArithOpAMask = 16'h0030;
  localparam logic [15:0] ArithOpBMask = 16'h00C0;
  localparam logic [15:0] LogicOpAMask = 16'h0340;
  localparam logic [15:0] LogicOpBMask = 16'h0C80;
  localparam logic [3:0]  ArithLastCmd = 4'd10;
  localparam logic [3:0]  LogicLastCmd = 4'd13;

  function automatic logic is_valid_cmd(logic mode, logic [3:0] cmd);
    return mode ? (cmd <= ArithLastCmd) : (cmd <= LogicLastCmd);
  endfunction

  function automatic logic is_op_a(logic mode, logic [3:0] cmd);
    return mode ? ArithOpAMask[cmd] : LogicOpAMask[cmd];
  endfunction

  function automatic logic is_op_b(logic mode, logic [3:0] cmd);
    return mode ? ArithOpBMask[cmd] : LogicOpBMask[cmd];
  endfunction

  function automatic logic is_two_op(logic mode, logic [3:0] cmd);
    return is_valid_cmd(mode, cmd) && !is_op_a(mode, cmd) && !is_op_b(mode, cmd);
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational operation evaluation and flag generation; multiply results are
// staged by the core before presentation.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cin,
  input  logic           mode,
  input  logic [3:0]     cmd,
  output logic [2*W-1:0] res,
  output logic           cout,
  output logic           oflow,
  output logic           g,
  output logic           l,
  output logic           e,
  output logic           err,
  output logic           is_mul
);

  localparam int unsigned SHW = $clog2(W);

  logic           carry;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W:0]     a_inc;
  logic [W:0]     b_inc;
  logic [W-1:0]   a_dec;
  logic [W-1:0]   b_dec;
  logic [W-1:0]   a_shl;
  logic [2*W-1:0] prod_inc;
  logic [2*W-1:0] prod_shl;
  logic [SHW-1:0] amt;
  logic           rot_bad;
  logic [W-1:0]   rol_w;
  logic [W-1:0]   ror_w;

  assign carry    = cin & ((cmd == ArithAddCin) || (cmd == ArithSubCin));
  assign sum      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry};
  // Bit W of the difference is the borrow out of a - b - cin.
  assign diff     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, carry};
  assign a_inc    = {1'b0, a} + {{W{1'b0}}, 1'b1};
  assign b_inc    = {1'b0, b} + {{W{1'b0}}, 1'b1};
  assign a_dec    = a - {{(W-1){1'b0}}, 1'b1};
  assign b_dec    = b - {{(W-1){1'b0}}, 1'b1};
  assign a_shl    = a << 1;
  assign prod_inc = {{(W-1){1'b0}}, a_inc} * {{(W-1){1'b0}}, b_inc};
  assign prod_shl = {{W{1'b0}}, a_shl} * {{W{1'b0}}, b};
  assign amt      = b[SHW-1:0];
  assign rot_bad  = |b[W-1:SHW];
  assign rol_w    = W'(({a, a} << amt) >> W);
  assign ror_w    = W'({a, a} >> amt);

  always_comb begin
    res    = '0;
    cout   = 1'b0;
    oflow  = 1'b0;
    g      = 1'b0;
    l      = 1'b0;
    e      = 1'b0;
    err    = 1'b0;
    is_mul = 1'b0;
    if (mode) begin
      case (cmd)
        ArithAdd, ArithAddCin: begin
          res  = {{(W-1){1'b0}}, sum};
          cout = sum[W];
        end
        ArithSub, ArithSubCin: begin
          res   = {{W{1'b0}}, diff[W-1:0]};
          oflow = diff[W];
        end
        ArithIncA: begin
          res  = {{W{1'b0}}, a_inc[W-1:0]};
          cout = a_inc[W];
        end
        ArithDecA: begin
          res   = {{W{1'b0}}, a_dec};
          oflow = (a == '0);
        end
        ArithIncB: begin
          res  = {{W{1'b0}}, b_inc[W-1:0]};
          cout = b_inc[W];
        end
        ArithDecB: begin
          res   = {{W{1'b0}}, b_dec};
          oflow = (b == '0);
        end
        ArithCmp: begin
          g = (a > b);
          l = (a < b);
          e = (a == b);
        end
        ArithMulInc: begin
          res    = prod_inc;
          is_mul = 1'b1;
        end
        ArithMulShl: begin
          res    = prod_shl;
          is_mul = 1'b1;
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (cmd)
        LogicAnd:   res = {{W{1'b0}}, a & b};
        LogicNand:  res = {{W{1'b0}}, ~(a & b)};
        LogicOr:    res = {{W{1'b0}}, a | b};
        LogicNor:   res = {{W{1'b0}}, ~(a | b)};
        LogicXor:   res = {{W{1'b0}}, a ^ b};
        LogicXnor:  res = {{W{1'b0}}, ~(a ^ b)};
        LogicNotA:  res = {{W{1'b0}}, ~a};
        LogicNotB:  res = {{W{1'b0}}, ~b};
        LogicShr1A: res = {{W{1'b0}}, a >> 1};
        LogicShl1A: res = {{W{1'b0}}, a_shl};
        LogicShr1B: res = {{W{1'b0}}, b >> 1};
        LogicShl1B: res = {{W{1'b0}}, b << 1};
        LogicRolAB: begin
          err = rot_bad;
          res = rot_bad ? '0 : {{W{1'b0}}, rol_w};
        end
        LogicRorAB: begin
          err = rot_bad;
          res = rot_bad ? '0 : {{W{1'b0}}, ror_w};
        end
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe_core.sv
// Parametrised ALU core: operand pairing FSM with timeout, two-cycle multiply
// stage and fully registered outputs.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic [W-1:0]   opa,
  input  logic [W-1:0]   opb,
  input  logic           cin,
  input  logic           mode,
  input  logic [3:0]     cmd,
  input  logic [1:0]     inp_valid,
  output logic [2*W-1:0] res,
  output logic           out_valid,
  output logic           busy,
  output logic           oflow,
  output logic           cout,
  output logic           g,
  output logic           l,
  output logic           e,
  output logic           err
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  state_e         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           cin_q;
  logic           mode_q;
  logic [3:0]     cmd_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] mul_q;

  logic [W-1:0]   ex_a;
  logic [W-1:0]   ex_b;
  logic           ex_cin;
  logic           ex_mode;
  logic [3:0]     ex_cmd;
  logic [2*W-1:0] ex_res;
  logic           ex_cout;
  logic           ex_oflow;
  logic           ex_g;
  logic           ex_l;
  logic           ex_e;
  logic           ex_err;
  logic           ex_is_mul;

  logic va;
  logic vb;
  logic in_go;
  logic fire;
  logic timed_out;

  assign va = inp_valid[0];
  assign vb = inp_valid[1];

  // While waiting, the latched operand and its cmd/mode/cin override the bus.
  always_comb begin
    ex_a    = opa;
    ex_b    = opb;
    ex_cin  = cin;
    ex_mode = mode;
    ex_cmd  = cmd;
    case (state_q)
      StWaitA: begin
        ex_b    = b_q;
        ex_cin  = cin_q;
        ex_mode = mode_q;
        ex_cmd  = cmd_q;
      end
      StWaitB: begin
        ex_a    = a_q;
        ex_cin  = cin_q;
        ex_mode = mode_q;
        ex_cmd  = cmd_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (!is_valid_cmd(mode, cmd)) begin
      in_go = va | vb;
    end else if (is_op_a(mode, cmd)) begin
      in_go = va;
    end else if (is_op_b(mode, cmd)) begin
      in_go = vb;
    end else begin
      in_go = va & vb;
    end
  end

  always_comb begin
    case (state_q)
      StIdle:  fire = in_go;
      StWaitA: fire = va;
      StWaitB: fire = vb;
      default: fire = 1'b0;
    endcase
  end

  assign timed_out = ((state_q == StWaitA) || (state_q == StWaitB)) && !fire &&
                     (cnt_q == CW'(TIMEOUT - 1));

  alu_exec #(
    .W(W)
  ) u_exec (
    .a      (ex_a),
    .b      (ex_b),
    .cin    (ex_cin),
    .mode   (ex_mode),
    .cmd    (ex_cmd),
    .res    (ex_res),
    .cout   (ex_cout),
    .oflow  (ex_oflow),
    .g      (ex_g),
    .l      (ex_l),
    .e      (ex_e),
    .err    (ex_err),
    .is_mul (ex_is_mul)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      mode_q    <= 1'b0;
      cmd_q     <= '0;
      cnt_q     <= '0;
      mul_q     <= '0;
      res       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      oflow     <= 1'b0;
      cout      <= 1'b0;
      g         <= 1'b0;
      l         <= 1'b0;
      e         <= 1'b0;
      err       <= 1'b0;
    end else if (cen) begin
      out_valid <= 1'b0;
      if (state_q == StMul) begin
        res       <= mul_q;
        {cout, oflow, g, l, e, err} <= '0;
        out_valid <= 1'b1;
        busy      <= 1'b0;
        state_q   <= StIdle;
      end else if (fire && ex_is_mul) begin
        mul_q   <= ex_res;
        busy    <= 1'b1;
        state_q <= StMul;
      end else if (fire) begin
        res       <= ex_res;
        cout      <= ex_cout;
        oflow     <= ex_oflow;
        g         <= ex_g;
        l         <= ex_l;
        e         <= ex_e;
        err       <= ex_err;
        out_valid <= 1'b1;
        state_q   <= StIdle;
      end else if (timed_out) begin
        res       <= '0;
        {cout, oflow, g, l, e} <= '0;
        err       <= 1'b1;
        out_valid <= 1'b1;
        state_q   <= StIdle;
      end else if ((state_q == StIdle) && is_two_op(mode, cmd) && (va ^ vb)) begin
        a_q     <= opa;
        b_q     <= opb;
        cin_q   <= cin;
        mode_q  <= mode;
        cmd_q   <= cmd;
        cnt_q   <= '0;
        state_q <= va ? StWaitB : StWaitA;
      end else if (state_q != StIdle) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_core.sv
// Scoreboard bench for alu_pipe_core: directed scenarios plus randomized ops,
// with expected results from an arithmetic reference model.
module tb_alu_pipe_core;

  localparam int W  = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        cin;
  logic        mode;
  logic [3:0]  cmd;
  logic [1:0]  inp_valid;
  logic [15:0] res;
  logic        out_valid;
  logic        busy;
  logic        oflow;
  logic        cout;
  logic        g;
  logic        l;
  logic        e;
  logic        err;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        oflow;
    logic        g;
    logic        l;
    logic        e;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   checks   = 0;
  int   errors   = 0;
  int   ecyc     = 0;
  logic last_en  = 1'b0;
  logic last_rst = 1'b1;

  always #5 clk = ~clk;

  alu_pipe_core #(
    .W       (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .opa       (opa),
    .opb       (opb),
    .cin       (cin),
    .mode      (mode),
    .cmd       (cmd),
    .inp_valid (inp_valid),
    .res       (res),
    .out_valid (out_valid),
    .busy      (busy),
    .oflow     (oflow),
    .cout      (cout),
    .g         (g),
    .l         (l),
    .e         (e),
    .err       (err)
  );

  // 0 = invalid, 1 = A only, 2 = B only, 3 = both operands
  function automatic int need(int m, int cm);
    if (m == 1) begin
      if (cm <= 3 || (cm >= 8 && cm <= 10)) return 3;
      if (cm == 4 || cm == 5) return 1;
      if (cm == 6 || cm == 7) return 2;
      return 0;
    end
    if (cm <= 5 || cm == 12 || cm == 13) return 3;
    if (cm == 6 || cm == 8 || cm == 9) return 1;
    if (cm == 7 || cm == 10 || cm == 11) return 2;
    return 0;
  endfunction

  function automatic bit is_mul(int m, int cm);
    return (m == 1) && (cm == 9 || cm == 10);
  endfunction

  function automatic exp_t model(int a, int b, int c, int m, int cm);
    exp_t x;
    int   r;
    int   amt;
    x   = '{default: 0};
    r   = 0;
    amt = b % 8;
    if (m == 1) begin
      case (cm)
        0:  begin r = a + b;             x.cout  = (r > 255);   end
        1:  begin r = (a - b) & 255;     x.oflow = (a < b);     end
        2:  begin r = a + b + c;         x.cout  = (r > 255);   end
        3:  begin r = (a - b - c) & 255; x.oflow = (a < b + c); end
        4:  begin r = (a + 1) & 255;     x.cout  = (a == 255);  end
        5:  begin r = (a - 1) & 255;     x.oflow = (a == 0);    end
        6:  begin r = (b + 1) & 255;     x.cout  = (b == 255);  end
        7:  begin r = (b - 1) & 255;     x.oflow = (b == 0);    end
        8:  begin x.g = (a > b); x.l = (a < b); x.e = (a == b); end
        9:  r = ((a + 1) * (b + 1)) % 65536;
        10: r = ((a * 2) % 256) * b;
        default: x.err = 1'b1;
      endcase
    end else begin
      case (cm)
        0:  r = a & b;
        1:  r = ~(a & b) & 255;
        2:  r = a | b;
        3:  r = ~(a | b) & 255;
        4:  r = a ^ b;
        5:  r = ~(a ^ b) & 255;
        6:  r = ~a & 255;
        7:  r = ~b & 255;
        8:  r = a / 2;
        9:  r = (a * 2) % 256;
        10: r = b / 2;
        11: r = (b * 2) % 256;
        12: if (b >= 8) x.err = 1'b1; else r = ((a << amt) | (a >> (8 - amt))) & 255;
        13: if (b >= 8) x.err = 1'b1; else r = ((a >> amt) | (a << (8 - amt))) & 255;
        default: x.err = 1'b1;
      endcase
    end
    x.res = 16'(r);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [1:0] iv, int a, int b, int c, int m, int cm);
    inp_valid = iv;
    opa       = 8'(a);
    opb       = 8'(b);
    cin       = 1'(c);
    mode      = 1'(m);
    cmd       = 4'(cm);
    cen       = 1'b1;
    tick();
  endtask

  task automatic junk(logic [1:0] iv);
    drive(iv, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(1, 0),
          $urandom_range(1, 0), $urandom_range(15, 0));
  endtask

  // Disabled cycle with arbitrary inputs that must have no effect.
  task automatic gap();
    cen       = 1'b0;
    inp_valid = 2'($urandom_range(3, 0));
    opa       = 8'($urandom_range(255, 0));
    opb       = 8'($urandom_range(255, 0));
    cmd       = 4'($urandom_range(15, 0));
    tick();
    cen = 1'b1;
  endtask

  task automatic expect_op(int a, int b, int c, int m, int cm);
    exp_t x;
    x     = model(a, b, c, m, cm);
    x.due = ecyc + (is_mul(m, cm) ? 2 : 1);
    sb.push_back(x);
  endtask

  task automatic expect_timeout();
    exp_t x;
    x     = '{default: 0};
    x.err = 1'b1;
    x.due = ecyc + 1 + TO;
    sb.push_back(x);
  endtask

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_zero(string name);
    check(name, int'({res, out_valid, busy, oflow, cout, g, l, e, err}), 0);
  endtask

  always @(posedge clk) begin
    last_en  <= cen;
    last_rst <= rst;
    if (cen && !rst) ecyc <= ecyc + 1;
  end

  always @(negedge clk) begin
    if (last_en && !last_rst) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got res=%0h err=%0b at cycle %0d, want no result",
                   res, err, ecyc);
        end else begin
          mx = sb.pop_front();
          if ({res, cout, oflow, g, l, e, err} !==
              {mx.res, mx.cout, mx.oflow, mx.g, mx.l, mx.e, mx.err} || ecyc != mx.due) begin
            errors++;
            $display("FAIL result: got res=%0h c=%0b o=%0b g=%0b l=%0b e=%0b err=%0b cyc=%0d, want res=%0h c=%0b o=%0b g=%0b l=%0b e=%0b err=%0b cyc=%0d",
                     res, cout, oflow, g, l, e, err, ecyc,
                     mx.res, mx.cout, mx.oflow, mx.g, mx.l, mx.e, mx.err, mx.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due < ecyc) begin
        checks++;
        errors++;
        $display("FAIL missing_result: got none by cycle %0d, want res=%0h err=%0b due %0d",
                 ecyc, sb[0].res, sb[0].err, sb[0].due);
        mx = sb.pop_front();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cen = 1'b1; inp_valid = 2'b00;
    opa = '0; opb = '0; cin = 1'b0; mode = 1'b0; cmd = '0;
    tick();
    tick();
    check_zero("reset_state");
    rst = 1'b0;

    expect_op(200, 100, 0, 1, 0);
    drive(2'b11, 200, 100, 0, 1, 0);
    check("add_res", res, 16'h12C);
    check("add_cout", cout, 1);

    expect_op(3, 4, 0, 1, 9);
    drive(2'b11, 3, 4, 0, 1, 9);
    check("mul_busy", busy, 1);
    check("mul_no_valid_yet", out_valid, 0);
    drive(2'b11, 50, 60, 0, 1, 0);
    check("mul_res", res, 20);
    check("mul_busy_clear", busy, 0);

    expect_op(8'h81, 8'h01, 0, 0, 12);
    drive(2'b11, 8'h81, 8'h01, 0, 0, 12);
    check("rol_res", res, 3);
    expect_op(8'h81, 8'h11, 0, 0, 12);
    drive(2'b11, 8'h81, 8'h11, 0, 0, 12);
    check("rol_err", err, 1);

    // Arrival cycle carries different cmd/mode/cin: the latched ones must win.
    drive(2'b01, 5, 0, 0, 1, 0);
    junk(2'b00);
    junk(2'b00);
    expect_op(5, 7, 0, 1, 0);
    drive(2'b10, 99, 7, 1, 0, 5);
    check("split_add_res", res, 12);

    expect_timeout();
    drive(2'b01, 9, 0, 0, 1, 0);
    repeat (TO) junk(2'b00);
    check("timeout_err", err, 1);
    expect_op(1, 2, 0, 1, 0);
    drive(2'b11, 1, 2, 0, 1, 0);
    check("after_timeout_idle", res, 3);

    expect_timeout();
    drive(2'b01, 9, 0, 0, 1, 1);
    repeat (3) junk(2'b00);
    repeat (5) gap();
    repeat (TO - 4) junk(2'b00);
    check("cen_timeout_not_yet", out_valid, 0);
    junk(2'b00);
    check("cen_timeout_err", err, 1);

    drive(2'b11, 3, 4, 0, 1, 9);
    check("rst_mul_busy", busy, 1);
    rst = 1'b1;
    cen = 1'b0;
    tick();
    check_zero("rst_during_mul");
    rst = 1'b0;
    junk(2'b00);
    check("rst_mul_dropped", out_valid, 0);

    for (int n = 0; n < 400; n++) begin
      int m, cm, a, b, c, nd, a2, b2;
      logic [1:0] iv;
      m  = $urandom_range(1, 0);
      cm = $urandom_range(15, 0);
      a  = $urandom_range(255, 0);
      b  = ($urandom_range(1, 0) == 1) ? $urandom_range(7, 0) : $urandom_range(255, 0);
      c  = $urandom_range(1, 0);
      a2 = $urandom_range(255, 0);
      b2 = $urandom_range(255, 0);
      nd = need(m, cm);
      if ($urandom_range(4, 0) == 0) gap();
      if ($urandom_range(3, 0) == 0) junk(2'b00);
      if (nd == 3 && $urandom_range(1, 0) == 1) begin
        if ($urandom_range(1, 0) == 1) begin
          drive(2'b01, a, b, c, m, cm);
          for (int k = $urandom_range(3, 0); k > 0; k--) begin
            if ($urandom_range(1, 0) == 1) gap(); else junk(2'b00);
          end
          expect_op(a, b2, c, m, cm);
          drive({1'b1, 1'($urandom_range(1, 0))}, a2, b2, $urandom_range(1, 0),
                $urandom_range(1, 0), $urandom_range(15, 0));
        end else begin
          drive(2'b10, a, b, c, m, cm);
          for (int k = $urandom_range(3, 0); k > 0; k--) begin
            if ($urandom_range(1, 0) == 1) gap(); else junk(2'b00);
          end
          expect_op(a2, b, c, m, cm);
          drive({1'($urandom_range(1, 0)), 1'b1}, a2, b2, $urandom_range(1, 0),
                $urandom_range(1, 0), $urandom_range(15, 0));
        end
      end else begin
        case (nd)
          1:       iv = {1'($urandom_range(1, 0)), 1'b1};
          2:       iv = {1'b1, 1'($urandom_range(1, 0))};
          3:       iv = 2'b11;
          default: iv = 2'($urandom_range(3, 1));
        endcase
        expect_op(a, b, c, m, cm);
        drive(iv, a, b, c, m, cm);
      end
      if (is_mul(m, cm)) junk(2'b11);
    end

    repeat (3) junk(2'b00);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
